// File: rtl/sample_recorder.sv
// -----------------------------------------------------------------------------
// sample_recorder
//
// Records a 4-bit sample stream into an external synchronous RAM at a fixed
// sample rate. It then plays the recording back in a continuous loop as the
// same 4-bit stream. This block is the writer-side companion of the ROM-based
// song player, and it drives the shared audio `data` bus.
//
// Parameters
//   TICK_DIV  clocks per sample period (4..65535)
//   DEPTH     RAM capacity in samples (<= 2**ADDR_W)
//   ADDR_W    RAM address width
//
// Ports
//   clk50Mghz  board clock; all logic runs on its rising edge
//   rst_n      asynchronous active-low reset
//   rec        record request level (asynchronous, synchronized here)
//   play       playback request level (asynchronous, synchronized here)
//   sample_in  sample to record; sampled on the tick cycle
//   mem_we     RAM write strobe, one clock per recorded sample
//   mem_addr   RAM address shared by writes and reads
//   mem_wdata  RAM write data
//   mem_rdata  RAM read data, valid in the clock after mem_addr changes
//   data       playback sample stream (0 when not playing)
//   length     number of valid recorded samples
//   busy       high while recording or playing
//   full       sticky: the last recording stopped because it reached DEPTH
// -----------------------------------------------------------------------------
module sample_recorder #(
  parameter int TICK_DIV = 6250,
  parameter int DEPTH    = 25630,
  parameter int ADDR_W   = 15
) (
  input  logic              clk50Mghz,
  input  logic              rst_n,
  input  logic              rec,
  input  logic              play,
  input  logic [3:0]        sample_in,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wdata,
  input  logic [3:0]        mem_rdata,
  output logic [3:0]        data,
  output logic [ADDR_W-1:0] length,
  output logic              busy,
  output logic              full
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
  // One extra bit so that "pointer+1 == DEPTH" works even when DEPTH == 2**ADDR_W.
  localparam logic [ADDR_W:0]  DEPTH_V   = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RECORD = 2'd1,
    S_PLAY   = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t              state_q,     state_d;
  logic [1:0]          rec_sync_q,  rec_sync_d;
  logic [1:0]          play_sync_q, play_sync_d;
  logic [CNT_W-1:0]    cnt_q,       cnt_d;
  logic [ADDR_W-1:0]   ptr_q,       ptr_d;
  logic [ADDR_W-1:0]   length_q,    length_d;
  logic                full_q,      full_d;
  logic                we_q,        we_d;
  logic [ADDR_W-1:0]   addr_q,      addr_d;
  logic [3:0]          wdata_q,     wdata_d;
  logic [3:0]          data_q,      data_d;
  // A playback read address went out on the previous edge; capture mem_rdata.
  logic                rd_pend_q,   rd_pend_d;
  // Set when a recording ends on DEPTH. It stops a still-held `rec` from
  // immediately starting a new recording over the one just made.
  logic                rec_block_q, rec_block_d;

  logic                rec_s;
  logic                play_s;
  logic                rec_go;
  logic                tick;
  logic [ADDR_W:0]     ptr_inc;
  logic [ADDR_W-1:0]   length_m1;

  assign rec_s     = rec_sync_q[1];
  assign play_s    = play_sync_q[1];
  assign rec_go    = rec_s & ~rec_block_q;
  assign tick      = (state_q != S_IDLE) && (cnt_q == TICK_LAST);
  assign ptr_inc   = {1'b0, ptr_q} + {{ADDR_W{1'b0}}, 1'b1};
  assign length_m1 = length_q - {{(ADDR_W-1){1'b0}}, 1'b1};

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case statement. If any
    //       branch left one unassigned, synthesis would infer a latch.
    state_d     = state_q;
    rec_sync_d  = {rec_sync_q[0], rec};
    play_sync_d = {play_sync_q[0], play};
    ptr_d       = ptr_q;
    length_d    = length_q;
    full_d      = full_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    data_d      = data_q;
    rd_pend_d   = 1'b0;
    rec_block_d = rec_block_q & rec_s;

    unique case (state_q)
      S_IDLE: begin
        data_d = 4'h0;
        if (rec_go) begin
          state_d  = S_RECORD;
          ptr_d    = '0;
          length_d = '0;
          full_d   = 1'b0;
        end else if (play_s && (length_q != '0)) begin
          state_d = S_PLAY;
          ptr_d   = '0;
        end
      end

      S_RECORD: begin
        if (!rec_s) begin
          // A write strobe issued on an earlier tick is already on the bus
          // and finishes by itself. length keeps the count written so far.
          state_d = S_IDLE;
        end else if (tick) begin
          we_d     = 1'b1;
          addr_d   = ptr_q;
          wdata_d  = sample_in;
          ptr_d    = ptr_inc[ADDR_W-1:0];
          length_d = ptr_inc[ADDR_W-1:0];
          if (ptr_inc == DEPTH_V) begin
            // The final write and the return to IDLE happen on the same edge.
            full_d      = 1'b1;
            state_d     = S_IDLE;
            rec_block_d = 1'b1;
          end
        end
      end

      S_PLAY: begin
        if (rd_pend_q) begin
          data_d = mem_rdata;
        end
        if (rec_go) begin
          state_d  = S_RECORD;
          ptr_d    = '0;
          length_d = '0;
          full_d   = 1'b0;
          data_d   = 4'h0;
        end else if (!play_s) begin
          state_d = S_IDLE;
          data_d  = 4'h0;
        end else if (tick) begin
          addr_d    = ptr_q;
          rd_pend_d = 1'b1;
          ptr_d     = (ptr_q == length_m1) ? '0 : ptr_inc[ADDR_W-1:0];
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The tick counter restarts on every state change. Because of this, the
    // first sample of a run always lands TICK_DIV clocks after entry.
    if ((state_d != state_q) || (state_q == S_IDLE) || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: this block resets only the control state and the output registers.
  //       The sample memory is the external RAM, and nothing clears it. An
  //       old recording cannot be played because length returns to 0.
  always_ff @(posedge clk50Mghz or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rec_sync_q  <= 2'b00;
      play_sync_q <= 2'b00;
      cnt_q       <= '0;
      ptr_q       <= '0;
      length_q    <= '0;
      full_q      <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 4'h0;
      data_q      <= 4'h0;
      rd_pend_q   <= 1'b0;
      rec_block_q <= 1'b0;
    end else begin
      // NOTE: use non-blocking assignments here. Every flop then samples the
      //       value from before the edge, whatever order the lines are in.
      state_q     <= state_d;
      rec_sync_q  <= rec_sync_d;
      play_sync_q <= play_sync_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      length_q    <= length_d;
      full_q      <= full_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      data_q      <= data_d;
      rd_pend_q   <= rd_pend_d;
      rec_block_q <= rec_block_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign data      = data_q;
  assign length    = length_q;
  assign full      = full_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: doc/sample_recorder.md
# sample_recorder

Records a 4-bit audio sample stream into an external synchronous RAM at a fixed sample rate and plays it back in a loop. It is the writer-side counterpart of the song player. The player only reads a fixed ROM; this block fills a RAM from a sampler input and then reads it back as the same 4-bit stream for the existing audio output path. It sits between the board's sample source and the shared audio `data` bus, clocked from the 50 MHz board clock.

## Interface
- `TICK_DIV`, 6250: clocks per sample period (8 kHz at 50 MHz); legal range 4..65535.
- `DEPTH`, 25630: RAM capacity in samples; must be ≤ 2^ADDR_W.
- `ADDR_W`, 15: RAM address width.
- `clk50Mghz` in 1: board clock; all logic on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `rec` in 1: record request, level; asynchronous to the block.
- `play` in 1: playback request, level; asynchronous to the block.
- `sample_in` in 4: sample to record; stable around the sample tick.
- `mem_we` out 1: RAM write strobe.
- `mem_addr` out ADDR_W: RAM address for both read and write.
- `mem_wdata` out 4: RAM write data.
- `mem_rdata` in 4: RAM read data; valid 1 clock after `mem_addr`.
- `data` out 4: playback sample stream.
- `length` out ADDR_W: number of valid recorded samples.
- `busy` out 1: high in RECORD or PLAY.
- `full` out 1: sticky; last recording hit DEPTH.

## Operation
- `rec` and `play` each pass through a 2-flop synchronizer; only the synchronized levels (`rec_s`, `play_s`) are used.
- Tick counter: counts 0..TICK_DIV-1 and wraps. `tick` is high on the cycle where count equals TICK_DIV-1. The counter clears to 0 on every state entry, so the first tick falls TICK_DIV cycles after entry.
- State IDLE:
  - `rec_s`=1 → RECORD. Pointer clears to 0, `length` clears to 0, `full` clears.
  - Else if `play_s`=1 and `length`≠0 → PLAY. Pointer clears to 0.
  - `play_s`=1 with `length`=0 stays in IDLE.
  - `rec` has priority over `play`.
- State RECORD, on each tick:
  - `sample_in` is captured into `mem_wdata`, `mem_addr` ← pointer, `mem_we` pulses.
  - Pointer increments; `length` ← pointer+1.
  - When `length` reaches DEPTH: `full` ← 1, → IDLE. No write beyond address DEPTH-1.
  - `rec_s`=0 → IDLE; `length` keeps its value; a write already issued completes.
- State PLAY, on each tick:
  - `mem_addr` ← pointer.
  - Pointer increments, or wraps to 0 when pointer = `length`-1. Playback loops continuously.
  - `mem_rdata` is registered into `data` one clock after the address is presented.
  - `play_s`=0 → IDLE, and `data` ← 0.
  - `rec_s`=1 during PLAY → RECORD directly; playback stops, `data` ← 0.
- `busy` = (state≠IDLE). `mem_we` is 0 outside RECORD.
- Reset (asynchronous, any state, mid-operation included):
  - State IDLE; counter, pointer, `length` = 0.
  - `mem_we`, `mem_addr`, `mem_wdata`, `data`, `busy`, `full` = 0.
  - RAM contents are not cleared, but `length`=0 makes them unplayable.

## Timing
- Request latency: `rec` or `play` edge → state change within 3 clocks (2 synchronizer stages + 1 registered transition).
- Record, tick on cycle T: at edge T+1, `mem_we`=1, `mem_addr`=pointer, `mem_wdata`=`sample_in` as of cycle T. `mem_we` returns to 0 at edge T+2. Exactly one write per tick.
- Play, tick on cycle T: `mem_addr` updates at edge T+1, the RAM returns data during T+1, and `data` updates at edge T+2. `data` holds its value for TICK_DIV cycles.
- Sample spacing: exactly TICK_DIV clocks between consecutive writes or reads.
- `length` and `full` update on the same edge as the corresponding `mem_we`.
- Transition to IDLE on DEPTH: at edge T+1 together with the final write; `busy` falls at that edge.

## Test plan
- Reset: drive `rst_n`=0 mid-RECORD with TICK_DIV=4, DEPTH=8 → all outputs 0 immediately, no clock needed; after release, `length`=0 and `play` is ignored.
- Record 3 samples: TICK_DIV=4, `rec`=1, `sample_in` = 0xA, 0x5, 0xC on successive ticks, then `rec`=0 → writes to addresses 0,1,2 spaced 4 clocks apart; `length`=3; `full`=0; `busy` low within 3 clocks of `rec` falling.
- Loop playback: after the above, `play`=1 with a RAM model → `data` sequence 0xA, 0x5, 0xC, 0xA, …, each value held 4 clocks; `mem_addr` wraps 2→0.
- Full: DEPTH=8, `rec` held high → exactly 8 writes (addresses 0..7); `full`=1, `length`=8; return to IDLE with `rec` still high and no re-entry into RECORD until `rec` toggles low then high.
- Priority and override: `rec`=`play`=1 from IDLE → RECORD. During PLAY, raise `rec` → RECORD within 3 clocks, `data`=0, `length` restarts at 0.
- Empty play: after reset, `play`=1 for 100 clocks → stays IDLE; `mem_addr`, `data`, `busy` remain 0.
